armleocpu_fetch: RTL and testbench

ARMLEOCPU_FETCH -- requirements
Module: armleocpu_fetch

---
 rtl/armleocpu_fetch.sv | 89 ++++++++
 tb/tb_armleocpu_fetch.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/armleocpu_fetch.sv
// armleocpu_fetch: instruction fetch stage driving the cache and feeding decode through a one-entry bundle buffer
module armleocpu_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [1:0]  c_cmd,
  output logic [31:0] c_address,
  input  logic        c_done,
  input  logic [3:0]  c_response,
  input  logic [31:0] c_load_data,
  input  logic        interrupt_pending,
  input  logic        dbg_mode,
  output logic        dbg_pipeline_busy,
  output logic        f2d_valid,
  output logic [1:0]  f2d_type,
  output logic [31:0] f2d_instr,
  output logic [31:0] f2d_pc,
  output logic [3:0]  f2d_resp,
  input  logic        d2f_ready,
  input  logic [1:0]  d2f_cmd,
  input  logic [31:0] d2f_branchtarget
);
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_FLUSHING, S_STALL} state_t;
  state_t state, state_nxt;
  logic [31:0] pc, pend_target, eff_target;
  logic kill, pend_flush, eff_flush;
  logic redirect, consume, buf_free, can_issue, take_irq, issue, outstanding, read_ok, apply_redirect;
  assign redirect = d2f_ready && (d2f_cmd == 2'd1 || d2f_cmd == 2'd2);
  assign consume = f2d_valid && d2f_ready;
  assign buf_free = !f2d_valid || (consume && d2f_cmd == 2'd0);
  assign can_issue = rst_n && state == S_FETCH && !dbg_mode && !redirect && buf_free;
  assign take_irq = can_issue && interrupt_pending;
  assign issue = can_issue && !interrupt_pending;
  assign outstanding = state == S_WAIT || state == S_FLUSHING;
  // a completing read only delivers if no redirect arrived while it was in flight
  assign read_ok = c_done && !kill && !redirect && (issue || state == S_WAIT);
  // an in-flight command must finish before the redirect takes effect
  assign apply_redirect = outstanding ? (c_done && (kill || redirect)) : redirect;
  assign eff_flush = redirect ? (d2f_cmd == 2'd1) : pend_flush;
  assign eff_target = redirect ? d2f_branchtarget : pend_target;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = apply_redirect ? (eff_flush ? S_FLUSHING : S_FETCH)
      : read_ok ? ((c_response != 4'd0) ? S_STALL : S_FETCH)
      : take_irq ? S_STALL
      : issue ? S_WAIT
      : (outstanding && c_done) ? S_FETCH
      : state;
  end
  always_comb begin
    c_cmd = (state == S_FLUSHING) ? 2'd2 : (state == S_WAIT || issue) ? 2'd1 : 2'd0;
    c_address = pc;
    dbg_pipeline_busy = f2d_valid || c_cmd != 2'd0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_VECTOR;
      kill <= 1'b0;
      pend_flush <= 1'b0;
      pend_target <= 32'd0;
      f2d_valid <= 1'b0;
      f2d_type <= 2'd0;
      f2d_instr <= 32'd0;
      f2d_pc <= 32'd0;
      f2d_resp <= 4'd0;
    end else begin
      if (apply_redirect) pc <= eff_target;
      else if (read_ok && c_response == 4'd0) pc <= pc + 32'd4;
      kill <= outstanding && !c_done && (kill || redirect);
      if (outstanding && !c_done && redirect) begin
        pend_flush <= d2f_cmd == 2'd1;
        pend_target <= d2f_branchtarget;
      end
      if (read_ok || take_irq) begin
        f2d_valid <= 1'b1;
        f2d_type <= take_irq ? 2'd1 : 2'd0;
        f2d_instr <= take_irq ? 32'd0 : c_load_data;
        f2d_pc <= pc;
        f2d_resp <= take_irq ? 4'd0 : c_response;
      end else if (consume || redirect) begin
        f2d_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_armleocpu_fetch.sv
// tb_armleocpu_fetch: directed scenarios with a latency-configurable cache model and a bundle scoreboard
module tb_armleocpu_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] c_cmd;
  logic [31:0] c_address;
  logic c_done;
  logic [3:0] c_response;
  logic [31:0] c_load_data;
  logic interrupt_pending = 1'b0;
  logic dbg_mode = 1'b0;
  logic dbg_pipeline_busy;
  logic f2d_valid;
  logic [1:0] f2d_type;
  logic [31:0] f2d_instr, f2d_pc;
  logic [3:0] f2d_resp;
  logic d2f_ready = 1'b0;
  logic [1:0] d2f_cmd = 2'd0;
  logic [31:0] d2f_branchtarget = 32'd0;
  int vectors = 0;
  int miscompares = 0;
  int lat = 0;
  int wait_cnt;
  logic data_by_addr = 1'b0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic [3:0] err_code = 4'd0;
  typedef struct { logic [1:0] t; logic [31:0] i; logic [31:0] p; logic [3:0] r; } bundle_t;
  bundle_t sb[$];
  bundle_t exp_b;

  armleocpu_fetch dut (
    .clk(clk), .rst_n(rst_n), .c_cmd(c_cmd), .c_address(c_address), .c_done(c_done),
    .c_response(c_response), .c_load_data(c_load_data), .interrupt_pending(interrupt_pending),
    .dbg_mode(dbg_mode), .dbg_pipeline_busy(dbg_pipeline_busy), .f2d_valid(f2d_valid),
    .f2d_type(f2d_type), .f2d_instr(f2d_instr), .f2d_pc(f2d_pc), .f2d_resp(f2d_resp),
    .d2f_ready(d2f_ready), .d2f_cmd(d2f_cmd), .d2f_branchtarget(d2f_branchtarget)
  );

  always #5 clk = ~clk;

  // cache model: completes a command once it has been held for lat cycles
  assign c_done = rst_n && (c_cmd != 2'd0) && (wait_cnt >= lat);
  assign c_load_data = data_by_addr ? (c_address ^ 32'hDEAD_0000) : 32'h0000_0013;
  assign c_response = (c_cmd == 2'd1 && c_address == err_addr) ? err_code : 4'd0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 0;
    else wait_cnt <= (c_cmd != 2'd0 && !c_done) ? wait_cnt + 1 : 0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] t, input logic [31:0] i, input logic [31:0] p, input logic [3:0] r);
    sb.push_back('{t: t, i: i, p: p, r: r});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic neg;
    @(negedge clk);
  endtask

  task automatic reset_dut;
    check("sb_drain", sb.size(), 0);
    sb.delete();
    rst_n = 1'b0;
    d2f_ready = 1'b0;
    d2f_cmd = 2'd0;
    d2f_branchtarget = 32'd0;
    interrupt_pending = 1'b0;
    dbg_mode = 1'b0;
    lat = 0;
    err_addr = 32'hFFFF_FFFF;
    err_code = 4'd0;
    tick;
    tick;
  endtask

  always @(negedge clk) begin
    if (rst_n && f2d_valid && d2f_ready) begin
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_bundle: got pc %h want no bundle", f2d_pc);
      end
      if (sb.size() != 0) begin
        exp_b = sb.pop_front();
        check("bundle_type", 32'(f2d_type), 32'(exp_b.t));
        check("bundle_instr", f2d_instr, exp_b.i);
        check("bundle_pc", f2d_pc, exp_b.p);
        check("bundle_resp", 32'(f2d_resp), 32'(exp_b.r));
      end
    end
  end

  initial begin
    // reset state, then back-to-back zero-wait fetch and a decode stall
    reset_dut;
    check("rst_valid", 32'(f2d_valid), 0);
    check("rst_type", 32'(f2d_type), 0);
    check("rst_instr", f2d_instr, 0);
    check("rst_pc", f2d_pc, 0);
    check("rst_resp", 32'(f2d_resp), 0);
    check("rst_cmd", 32'(c_cmd), 0);
    check("rst_busy", 32'(dbg_pipeline_busy), 0);
    check("rst_addr", c_address, 32'h2000);
    push(2'd0, 32'h13, 32'h2000, 4'd0);
    push(2'd0, 32'h13, 32'h2004, 4'd0);
    push(2'd0, 32'h13, 32'h2008, 4'd0);
    rst_n = 1'b1;
    d2f_ready = 1'b1;
    neg;
    check("first_cmd", 32'(c_cmd), 1);
    check("first_addr", c_address, 32'h2000);
    tick;
    tick;
    tick;
    d2f_ready = 1'b0;
    repeat (3) begin
      neg;
      check("hold_valid", 32'(f2d_valid), 1);
      check("hold_pc", f2d_pc, 32'h2008);
      check("hold_instr", f2d_instr, 32'h13);
      check("hold_cmd", 32'(c_cmd), 0);
      check("hold_addr", c_address, 32'h200C);
    end
    tick;
    d2f_ready = 1'b1;
    neg;
    tick;
    // branch while a read is outstanding kills that read
    reset_dut;
    data_by_addr = 1'b1;
    push(2'd0, 32'hDEAD_2000, 32'h2000, 4'd0);
    rst_n = 1'b1;
    d2f_ready = 1'b1;
    tick;
    lat = 2;
    neg;
    tick;
    d2f_cmd = 2'd2;
    d2f_branchtarget = 32'h8000;
    neg;
    check("kill_cmd", 32'(c_cmd), 1);
    check("kill_addr", c_address, 32'h2004);
    tick;
    d2f_cmd = 2'd0;
    neg;
    check("kill_hold_cmd", 32'(c_cmd), 1);
    check("kill_hold_addr", c_address, 32'h2004);
    tick;
    lat = 0;
    push(2'd0, 32'hDEAD_8000, 32'h8000, 4'd0);
    neg;
    check("kill_novalid", 32'(f2d_valid), 0);
    check("br_cmd", 32'(c_cmd), 1);
    check("br_addr", c_address, 32'h8000);
    tick;
    neg;
    tick;
    // error response stalls until a flush redirect
    reset_dut;
    err_addr = 32'h2008;
    err_code = 4'h3;
    push(2'd0, 32'hDEAD_2000, 32'h2000, 4'd0);
    push(2'd0, 32'hDEAD_2004, 32'h2004, 4'd0);
    push(2'd0, 32'hDEAD_2008, 32'h2008, 4'h3);
    rst_n = 1'b1;
    d2f_ready = 1'b1;
    tick;
    tick;
    tick;
    neg;
    check("err_stall_cmd", 32'(c_cmd), 0);
    tick;
    neg;
    check("err_stall_cmd2", 32'(c_cmd), 0);
    check("err_stall_valid", 32'(f2d_valid), 0);
    check("err_pc_held", c_address, 32'h2008);
    tick;
    d2f_cmd = 2'd1;
    d2f_branchtarget = 32'h200C;
    neg;
    check("flush_req_cmd", 32'(c_cmd), 0);
    tick;
    d2f_cmd = 2'd0;
    lat = 1;
    neg;
    check("flush_cmd", 32'(c_cmd), 2);
    tick;
    neg;
    check("flush_cmd_held", 32'(c_cmd), 2);
    tick;
    lat = 0;
    push(2'd0, 32'hDEAD_200C, 32'h200C, 4'd0);
    neg;
    check("post_flush_cmd", 32'(c_cmd), 1);
    check("post_flush_addr", c_address, 32'h200C);
    tick;
    neg;
    tick;
    // interrupt bundle, stall, then branch
    reset_dut;
    interrupt_pending = 1'b1;
    d2f_ready = 1'b1;
    rst_n = 1'b1;
    push(2'd1, 32'd0, 32'h2000, 4'd0);
    neg;
    check("irq_cmd", 32'(c_cmd), 0);
    tick;
    neg;
    check("irq_stall_cmd", 32'(c_cmd), 0);
    tick;
    neg;
    check("irq_stall_cmd2", 32'(c_cmd), 0);
    check("irq_stall_valid", 32'(f2d_valid), 0);
    tick;
    interrupt_pending = 1'b0;
    d2f_cmd = 2'd2;
    d2f_branchtarget = 32'h3000;
    neg;
    tick;
    d2f_cmd = 2'd0;
    push(2'd0, 32'hDEAD_3000, 32'h3000, 4'd0);
    neg;
    check("irq_br_cmd", 32'(c_cmd), 1);
    check("irq_br_addr", c_address, 32'h3000);
    tick;
    neg;
    tick;
    // redirect outranks interrupt, then pc wraps past the top of memory
    reset_dut;
    interrupt_pending = 1'b1;
    d2f_ready = 1'b1;
    d2f_cmd = 2'd2;
    d2f_branchtarget = 32'h4000;
    rst_n = 1'b1;
    neg;
    check("prio_cmd", 32'(c_cmd), 0);
    tick;
    d2f_cmd = 2'd0;
    push(2'd1, 32'd0, 32'h4000, 4'd0);
    neg;
    check("prio_irq_cmd", 32'(c_cmd), 0);
    tick;
    interrupt_pending = 1'b0;
    neg;
    tick;
    d2f_cmd = 2'd2;
    d2f_branchtarget = 32'hFFFF_FFFC;
    neg;
    tick;
    d2f_cmd = 2'd0;
    push(2'd0, 32'h2152_FFFC, 32'hFFFF_FFFC, 4'd0);
    push(2'd0, 32'hDEAD_0000, 32'h0, 4'd0);
    neg;
    check("wrap_addr_top", c_address, 32'hFFFF_FFFC);
    tick;
    neg;
    check("wrap_addr_zero", c_address, 32'h0);
    tick;
    neg;
    tick;
    // debug halt lets the outstanding read and the buffer drain
    reset_dut;
    push(2'd0, 32'hDEAD_2000, 32'h2000, 4'd0);
    push(2'd0, 32'hDEAD_2004, 32'h2004, 4'd0);
    rst_n = 1'b1;
    d2f_ready = 1'b1;
    tick;
    lat = 2;
    neg;
    tick;
    dbg_mode = 1'b1;
    d2f_ready = 1'b0;
    neg;
    check("dbg_out_cmd", 32'(c_cmd), 1);
    check("dbg_out_addr", c_address, 32'h2004);
    check("dbg_out_busy", 32'(dbg_pipeline_busy), 1);
    tick;
    neg;
    tick;
    neg;
    check("dbg_buf_cmd", 32'(c_cmd), 0);
    check("dbg_buf_valid", 32'(f2d_valid), 1);
    check("dbg_buf_busy", 32'(dbg_pipeline_busy), 1);
    tick;
    d2f_ready = 1'b1;
    neg;
    check("dbg_drain_cmd", 32'(c_cmd), 0);
    tick;
    neg;
    check("dbg_idle_valid", 32'(f2d_valid), 0);
    check("dbg_idle_busy", 32'(dbg_pipeline_busy), 0);
    check("dbg_idle_cmd", 32'(c_cmd), 0);
    tick;
    check("sb_final", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
